sym_upsampler: RTL and testbench

- Sits directly downstream of the clock generator and upstream of the pulse-shaping filter.
- Accepts 2-bit symbol words from the data source through a valid/ready handshake and buffers them in a small FIFO.
- Maps each symbol to a Gray-coded 4-ASK level.
- Emits one signed sample per sample-clock enable: the level on the symbol-phase sample, zeros on the other three (4x zero-stuffing).

---
 rtl/mod465_pkg.sv | 19 +
 rtl/sym_upsampler_if.sv | 26 ++
 rtl/sym_fifo.sv | 57 +++++
 rtl/sym_upsampler.sv | 129 ++++++++++++
 tb/tb_sym_upsampler.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mod465_pkg.sv
// Shared constants for the 4-ASK modem: sample width, level magnitudes,
// Gray symbol codes and the upsampler state encoding.
package mod465_pkg;

  localparam int SAMPLE_W = 18;
  localparam int LVL_A    = 32768;
  localparam int LVL_3A   = 3 * LVL_A;

  localparam logic [1:0] SYM_M3 = 2'b00;
  localparam logic [1:0] SYM_M1 = 2'b01;
  localparam logic [1:0] SYM_P1 = 2'b11;
  localparam logic [1:0] SYM_P3 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sym_upsampler_if.sv
// Symbol-in / sample-out stream bundle for sym_upsampler.
// master = data source and filter side, slave = the upsampler.
interface sym_upsampler_if
  import mod465_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W
);

  logic [1:0]               in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] out_sample;
  logic                     out_valid;
  logic                     out_sym_start;

  modport master (
    output in_data, in_valid,
    input  in_ready, out_sample, out_valid, out_sym_start
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out_sample, out_valid, out_sym_start
  );

endinterface

// File: rtl/sym_fifo.sv
// Single-clock FIFO with registered occupancy; synchronous active-low reset.
// Push when full and pop when empty are ignored.
module sym_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];
  assign level   = count;

  // NOTE: storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sym_upsampler.sv
// 4-ASK Gray mapper with 4x zero-stuffing behind a symbol FIFO.
// Define SYM_UPSAMPLER_HOLD_EN for sample-and-hold instead of zero-stuffing.
module sym_upsampler
  import mod465_pkg::*;
#(
  parameter int DATA_W     = SAMPLE_W,
  parameter int FIFO_DEPTH = 8,
  parameter int PRIME_LVL  = 2,
  parameter int LEVEL_A    = LVL_A
) (
  input  logic                        sys_clk,
  input  logic                        reset_n,
  input  logic                        sam_clk_ena,
  input  logic                        sym_clk_ena,
  sym_upsampler_if.slave              bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        running,
  output logic                        underflow
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic signed [DATA_W-1:0] S_P1 = DATA_W'(LEVEL_A);
  localparam logic signed [DATA_W-1:0] S_P3 = DATA_W'(3 * LEVEL_A);
  localparam logic signed [DATA_W-1:0] S_M1 = -S_P1;
  localparam logic signed [DATA_W-1:0] S_M3 = -S_P3;

  function automatic logic signed [DATA_W-1:0] gray_level(input logic [1:0] s);
    unique case (s)
      SYM_M3:  return S_M3;
      SYM_M1:  return S_M1;
      SYM_P1:  return S_P1;
      default: return S_P3;
    endcase
  endfunction

  state_t                   state_q, state_d;
  logic signed [DATA_W-1:0] sample_q, sample_d;
  logic                     valid_q;
  logic                     sym_start_q, sym_start_d;
  logic                     underflow_q, uf_set;
  logic                     push, pop, fifo_full, fifo_empty;
  logic [1:0]               head;
  logic                     sym_ev, primed;

  // in_ready follows the registered level, so a same-cycle pop cannot raise it.
  assign bus.in_ready = ~fifo_full;
  assign push         = bus.in_valid & ~fifo_full;

  sym_fifo #(
    .WIDTH (2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data (bus.in_data),
    .rd_data (head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign sym_ev = sym_clk_ena & sam_clk_ena;
  assign primed = (fifo_level >= LVL_W'(PRIME_LVL));

  // NOTE: every output of this block is defaulted first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    sym_start_d = 1'b0;
    uf_set      = 1'b0;
    pop         = 1'b0;
    if (sam_clk_ena) begin
`ifdef SYM_UPSAMPLER_HOLD_EN
      sample_d = (state_q == RUN) ? sample_q : '0;
`else
      sample_d = '0;
`endif
      if (sym_ev) begin
        unique case (state_q)
          IDLE: begin
            if (primed) begin
              state_d     = RUN;
              pop         = 1'b1;
              sample_d    = gray_level(head);
              sym_start_d = 1'b1;
            end
          end
          RUN: begin
            if (!fifo_empty) begin
              pop         = 1'b1;
              sample_d    = gray_level(head);
              sym_start_d = 1'b1;
            end else begin
              state_d  = IDLE;
              sample_d = '0;
              uf_set   = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      sym_start_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      valid_q     <= sam_clk_ena;
      sym_start_q <= sym_start_d;
      if (uf_set) underflow_q <= 1'b1;
    end
  end

  assign bus.out_sample    = sample_q;
  assign bus.out_valid     = valid_q;
  assign bus.out_sym_start = sym_start_q;
  assign running           = (state_q == RUN);
  assign underflow         = underflow_q;

endmodule

// File: tb/tb_sym_upsampler.sv
// Directed bench for sym_upsampler: the bench owns the 4/16 enable cadence
// and compares the captured output stream against hand-built expectations.
module tb_sym_upsampler;
  import mod465_pkg::*;

  localparam int DATA_W = 18;
  localparam int LVL_W  = 4;

  logic             sys_clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             sam_clk_ena = 1'b0;
  logic             sym_clk_ena = 1'b0;
  logic [LVL_W-1:0] fifo_level;
  logic             running;
  logic             underflow;

  sym_upsampler_if #(.DATA_W(DATA_W)) bus ();

  sym_upsampler #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (8),
    .PRIME_LVL  (2),
    .LEVEL_A    (32768)
  ) dut (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .sam_clk_ena (sam_clk_ena),
    .sym_clk_ena (sym_clk_ena),
    .bus         (bus.slave),
    .fifo_level  (fifo_level),
    .running     (running),
    .underflow   (underflow)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ph      = 0;   // phase (0..15) of the next rising edge
  bit sym_gate = 1'b1;

  int obs_val[$];
  bit obs_sym[$];
  int exp_val[$];
  bit exp_sym[$];

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lvl(input logic [1:0] s);
    case (s)
      2'b00:   return -98304;
      2'b01:   return -32768;
      2'b11:   return 32768;
      default: return 98304;
    endcase
  endfunction

  task automatic set_enables();
    sam_clk_ena = (ph % 4 == 0);
    sym_clk_ena = (ph == 0) && sym_gate;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (bus.out_valid === 1'b1) begin
      obs_val.push_back(int'($signed(bus.out_sample)));
      obs_sym.push_back(bus.out_sym_start);
    end
    ph = (ph + 1) % 16;
    set_enables();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_streams();
    obs_val.delete();
    obs_sym.delete();
    exp_val.delete();
    exp_sym.delete();
  endtask

  task automatic push_sym(input logic [1:0] d);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    while (ph != 1) tick();
    clear_streams();
  endtask

  task automatic exp_zero();
    exp_val.push_back(0);
    exp_sym.push_back(1'b0);
  endtask

  task automatic exp_symbol(input logic [1:0] s);
    int v;
    v = lvl(s);
    exp_val.push_back(v);
    exp_sym.push_back(1'b1);
    for (int k = 0; k < 3; k++) begin
`ifdef SYM_UPSAMPLER_HOLD_EN
      exp_val.push_back(v);
`else
      exp_val.push_back(0);
`endif
      exp_sym.push_back(1'b0);
    end
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, obs_val.size(), exp_val.size());
    for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
      check($sformatf("%s_val[%0d]", tag, i), obs_val[i], exp_val[i]);
      check($sformatf("%s_sym[%0d]", tag, i), 32'(obs_sym[i]), 32'(exp_sym[i]));
    end
  endtask

  logic [1:0] fill_pat [8];

  initial begin
    bus.in_data  = 2'b00;
    bus.in_valid = 1'b0;
    set_enables();

    // Reset asserted across a symbol event
    ticks(2);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_sample", $signed(bus.out_sample), 0);
    check("rst_sym_start", bus.out_sym_start, 1'b0);
    check("rst_level", fifo_level, 0);
    check("rst_running", running, 1'b0);
    check("rst_underflow", underflow, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);

    // Free-running enables, no input: 10 zero samples
    reset_n = 1'b1;
    clear_streams();
    ticks(40);
    for (int i = 0; i < 10; i++) exp_zero();
    compare_stream("idle");
    check("idle_running", running, 1'b0);
    check("idle_underflow", underflow, 1'b0);
    check("idle_in_ready", bus.in_ready, 1'b1);

    // One symbol is below the priming threshold
    push_sym(2'b11);
    ticks(7);
    check("prime1_running", running, 1'b0);
    check("prime1_level", fifo_level, 1);

    // Four symbols back-to-back, one of each level
    do_reset();
    push_sym(2'b00);
    push_sym(2'b01);
    push_sym(2'b11);
    push_sym(2'b10);
    check("map_level4", fifo_level, 4);
    check("map_idle", running, 1'b0);
    ticks(72);
    exp_zero(); exp_zero(); exp_zero();
    exp_symbol(2'b00);
    exp_symbol(2'b01);
    exp_symbol(2'b11);
    exp_symbol(2'b10);
    compare_stream("map");
    check("map_running", running, 1'b1);
    check("map_no_underflow", underflow, 1'b0);
    check("map_empty", fifo_level, 0);
    ticks(4);
    check("map_uf_flag", underflow, 1'b1);
    check("map_uf_idle", running, 1'b0);
    check("map_uf_sample", $signed(bus.out_sample), 0);

    // Fill to full with symbol events gated off, then drain with a push+pop
    fill_pat[0] = 2'b00; fill_pat[1] = 2'b01; fill_pat[2] = 2'b11; fill_pat[3] = 2'b10;
    fill_pat[4] = 2'b10; fill_pat[5] = 2'b11; fill_pat[6] = 2'b01; fill_pat[7] = 2'b00;
    sym_gate = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) push_sym(fill_pat[i]);
    check("full_level", fifo_level, 8);
    check("full_in_ready", bus.in_ready, 1'b0);
    bus.in_data  = 2'b11;
    bus.in_valid = 1'b1;
    ticks(3);
    bus.in_valid = 1'b0;
    check("full_hold_level", fifo_level, 8);
    check("full_hold_ready", bus.in_ready, 1'b0);
    sym_gate = 1'b1;
    clear_streams();
    ticks(84);
    check("drain_level3", fifo_level, 3);
    check("drain_ready", bus.in_ready, 1'b1);
    push_sym(2'b10);
    check("pushpop_level", fifo_level, 3);
    ticks(60);
    check("drain_running", running, 1'b1);
    check("drain_no_uf", underflow, 1'b0);
    check("drain_empty", fifo_level, 0);
    ticks(4);
    exp_zero();
    for (int i = 0; i < 8; i++) exp_symbol(fill_pat[i]);
    exp_symbol(2'b10);
    exp_zero();
    compare_stream("order");
    check("drain_uf_flag", underflow, 1'b1);
    check("drain_uf_idle", running, 1'b0);

    // Re-prime after underflow: two pushes restart RUN, flag stays sticky
    clear_streams();
    push_sym(2'b01);
    push_sym(2'b11);
    ticks(14);
    exp_zero(); exp_zero(); exp_zero();
    exp_val.push_back(lvl(2'b01));
    exp_sym.push_back(1'b1);
    compare_stream("reprime");
    check("reprime_running", running, 1'b1);
    check("reprime_uf_sticky", underflow, 1'b1);
    check("reprime_level", fifo_level, 1);

    // Reset mid-stream with five symbols buffered
    for (int i = 0; i < 4; i++) push_sym(2'b00);
    check("mid_level5", fifo_level, 5);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_sample", $signed(bus.out_sample), 0);
    check("mid_rst_valid", bus.out_valid, 1'b0);
    check("mid_rst_running", running, 1'b0);
    check("mid_rst_uf", underflow, 1'b0);
    check("mid_rst_ready", bus.in_ready, 1'b1);
    clear_streams();
    ticks(15);
    for (int i = 0; i < 4; i++) exp_zero();
    compare_stream("post_rst");
    check("post_rst_running", running, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
